// File: rtl/spi_lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_lcd_pkg
// Purpose : Shared opcodes, decoder state encoding and pixel type for the
//           SPI LCD receive-side model.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package spi_lcd_pkg;

    // Panel opcodes recognised by the decoder
    localparam logic [7:0] C_SLPIN   = 8'h10;
    localparam logic [7:0] C_SLPOUT  = 8'h11;
    localparam logic [7:0] C_DISPOFF = 8'h28;
    localparam logic [7:0] C_DISPON  = 8'h29;
    localparam logic [7:0] C_CASET   = 8'h2A;
    localparam logic [7:0] C_RASET   = 8'h2B;
    localparam logic [7:0] C_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CASET  = 3'd1,
        ST_RASET  = 3'd2,
        ST_RAMWR  = 3'd3,
        ST_IGNORE = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Window arguments arrive as two bytes, high first; each byte is merged
    // into the 16-bit view of the current register value as it arrives.
    function automatic logic [15:0] merge_arg(input logic [15:0] cur,
                                              input logic [7:0]  b,
                                              input logic        lo_half);
        return lo_half ? {cur[15:8], b} : {b, cur[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_lcd_sink_rx.sv
`default_nettype none
// ============================================================================
// Module  : spi_byte_rx
// Purpose : SPI byte receiver. Synchronises SCK/CS/DC/MOSI into clk, detects
//           SCK rising edges while CS is low, and assembles MSB-first bytes.
// Ports   : i_clk, i_resetn      - system clock, sync active-low reset
//           i_sck, i_cs_n,
//           i_dc, i_mosi         - raw SPI inputs
//           o_byte_valid         - one-cycle pulse, full byte received
//           o_byte, o_dc         - byte value and DC captured with bit 8
//           o_err                - pulse: CS rose with a partial byte
// Revision: 1.0 - initial release
// ============================================================================
module spi_byte_rx (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic       i_dc,
    input  logic       i_mosi,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_dc,
    output logic       o_err
);

    // [0],[1] form the two-flop synchroniser; [2] is the edge-detect history
    logic [2:0] r_sck_q;
    logic [2:0] r_cs_q;
    logic [1:0] r_dc_q;
    logic [1:0] r_mosi_q;
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic       r_byte_valid;
    logic [7:0] r_byte;
    logic       r_dc;
    logic       r_err;

    logic       w_sck_rise;
    logic       w_cs_rise;
    logic [7:0] w_shift_nxt;

    assign w_sck_rise  = r_sck_q[1] & ~r_sck_q[2];
    assign w_cs_rise   = r_cs_q[1] & ~r_cs_q[2];
    assign w_shift_nxt = {r_shift[6:0], r_mosi_q[1]};

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sck_q      <= 3'b000;
            r_cs_q       <= 3'b111;
            r_dc_q       <= 2'b00;
            r_mosi_q     <= 2'b00;
            r_shift      <= 8'h00;
            r_cnt        <= 3'd0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'h00;
            r_dc         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_sck_q      <= {r_sck_q[1:0], i_sck};
            r_cs_q       <= {r_cs_q[1:0], i_cs_n};
            r_dc_q       <= {r_dc_q[0], i_dc};
            r_mosi_q     <= {r_mosi_q[0], i_mosi};
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
            if (w_cs_rise) begin
                r_cnt <= 3'd0;
                r_err <= (r_cnt != 3'd0);
            end else if (w_sck_rise && !r_cs_q[1]) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte       <= w_shift_nxt;
                    r_dc         <= r_dc_q[1];
                end
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_dc         = r_dc;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: rtl/spi_lcd_sink.sv
`default_nettype none
// ============================================================================
// Module  : spi_lcd_sink
// Purpose : Receive-side model of a write-only ST7789-style SPI LCD link.
//           Decodes SLPIN/SLPOUT, DISPON/DISPOFF, CASET, RASET and RAMWR and
//           emits an RGB565 pixel stream with window coordinates.
// Ports   : i_clk, i_resetn               - clock, sync active-low reset
//           i_spi_sck/cs_n/dc/mosi        - SPI link from the driver
//           o_cmd_valid, o_cmd_byte       - command pulse / held opcode
//           o_pix_valid, o_pix_data,
//           o_pix_x, o_pix_y              - pixel pulse, value, coordinates
//           o_frame_done                  - last pixel of the window
//           o_sleep_out, o_display_on     - panel state levels
//           o_err                         - partial byte or invalid window
// Revision: 1.0 - initial release
// ============================================================================
module spi_lcd_sink
    import spi_lcd_pkg::*;
#(
    parameter int COORD_W = 9,
    parameter int DEF_XE  = 239,
    parameter int DEF_YE  = 134
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_spi_sck,
    input  logic               i_spi_cs_n,
    input  logic               i_spi_dc,
    input  logic               i_spi_mosi,
    output logic               o_cmd_valid,
    output logic [7:0]         o_cmd_byte,
    output logic               o_pix_valid,
    output logic [15:0]        o_pix_data,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic               o_frame_done,
    output logic               o_sleep_out,
    output logic               o_display_on,
    output logic               o_err
);

    logic               w_byte_valid;
    logic [7:0]         w_byte;
    logic               w_dc;
    logic               w_rx_err;

    dec_state_t         r_state;
    dec_state_t         w_state_nxt;
    logic [1:0]         r_arg_idx;
    logic               r_phase;
    logic [7:0]         r_hi;
    logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye;
    logic [COORD_W-1:0] r_x, r_y;

    logic               r_cmd_valid;
    logic [7:0]         r_cmd_byte;
    logic               r_pix_valid;
    rgb565_t            r_pix_data;
    logic [COORD_W-1:0] r_pix_x, r_pix_y;
    logic               r_frame_done;
    logic               r_sleep_out;
    logic               r_display_on;
    logic               r_err;

    logic               w_win_bad;
    logic [COORD_W-1:0] w_arg_cur;
    logic [COORD_W-1:0] w_arg_new;

    spi_byte_rx u_rx (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_sck        (i_spi_sck),
        .i_cs_n       (i_spi_cs_n),
        .i_dc         (i_spi_dc),
        .i_mosi       (i_spi_mosi),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_dc         (w_dc),
        .o_err        (w_rx_err)
    );

    // Argument index bit 1 selects start/end, bit 0 selects high/low byte.
    // Coordinates are assumed no wider than 16 bits.
    always_comb begin
        w_win_bad = (r_xs > r_xe) || (r_ys > r_ye);
        if (r_state == ST_CASET) begin
            w_arg_cur = r_arg_idx[1] ? r_xe : r_xs;
        end else begin
            w_arg_cur = r_arg_idx[1] ? r_ye : r_ys;
        end
        w_arg_new = COORD_W'(merge_arg(16'(w_arg_cur), w_byte, r_arg_idx[0]));
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_byte_valid) begin
            if (!w_dc) begin
                case (w_byte)
                    C_CASET: w_state_nxt = ST_CASET;
                    C_RASET: w_state_nxt = ST_RASET;
                    C_RAMWR: w_state_nxt = w_win_bad ? ST_IGNORE : ST_RAMWR;
                    default: w_state_nxt = ST_IGNORE;
                endcase
            end else if ((r_state == ST_CASET || r_state == ST_RASET) &&
                         r_arg_idx == 2'd3) begin
                w_state_nxt = ST_IGNORE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_arg_idx    <= 2'd0;
            r_phase      <= 1'b0;
            r_hi         <= 8'h00;
            r_xs         <= '0;
            r_xe         <= COORD_W'(DEF_XE);
            r_ys         <= '0;
            r_ye         <= COORD_W'(DEF_YE);
            r_x          <= '0;
            r_y          <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_byte   <= 8'h00;
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_frame_done <= 1'b0;
            r_sleep_out  <= 1'b0;
            r_display_on <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= w_rx_err;
            if (w_byte_valid) begin
                if (!w_dc) begin
                    // A command always ends any stream; a pending high byte
                    // is simply forgotten by clearing the phase.
                    r_cmd_valid <= 1'b1;
                    r_cmd_byte  <= w_byte;
                    r_arg_idx   <= 2'd0;
                    r_phase     <= 1'b0;
                    case (w_byte)
                        C_SLPOUT:  r_sleep_out  <= 1'b1;
                        C_SLPIN:   r_sleep_out  <= 1'b0;
                        C_DISPON:  r_display_on <= 1'b1;
                        C_DISPOFF: r_display_on <= 1'b0;
                        C_RAMWR: begin
                            r_x <= r_xs;
                            r_y <= r_ys;
                            if (w_win_bad) begin
                                r_err <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    case (r_state)
                        ST_CASET: begin
                            if (r_arg_idx[1]) r_xe <= w_arg_new;
                            else              r_xs <= w_arg_new;
                            r_arg_idx <= r_arg_idx + 2'd1;
                        end
                        ST_RASET: begin
                            if (r_arg_idx[1]) r_ye <= w_arg_new;
                            else              r_ys <= w_arg_new;
                            r_arg_idx <= r_arg_idx + 2'd1;
                        end
                        ST_RAMWR: begin
                            if (!r_phase) begin
                                r_hi    <= w_byte;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase     <= 1'b0;
                                r_pix_valid <= 1'b1;
                                r_pix_data  <= {r_hi, w_byte};
                                r_pix_x     <= r_x;
                                r_pix_y     <= r_y;
                                // Raster advance; past the window end the
                                // stream wraps to the window origin.
                                if (r_x == r_xe) begin
                                    r_x <= r_xs;
                                    if (r_y == r_ye) begin
                                        r_y          <= r_ys;
                                        r_frame_done <= 1'b1;
                                    end else begin
                                        r_y <= r_y + COORD_W'(1);
                                    end
                                end else begin
                                    r_x <= r_x + COORD_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_cmd_valid  = r_cmd_valid;
    assign o_cmd_byte   = r_cmd_byte;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_data   = r_pix_data;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_frame_done = r_frame_done;
    assign o_sleep_out  = r_sleep_out;
    assign o_display_on = r_display_on;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: doc/spi_lcd_sink.md
# spi_lcd_sink

Receive-side model of the 4-wire write-only SPI LCD link (ST7789-style, 240x135 panel) that the screen driver produces. It samples SCK/CS/DC/MOSI in the system clock domain, assembles bytes, and decodes the command set (SLPOUT/SLPIN, DISPON/DISPOFF, CASET, RASET, RAMWR). It emits a pixel stream with window coordinates, so frames sent by the driver can be checked, captured, or forwarded to a frame buffer.

## Interface
- `COORD_W`, default 9: coordinate width; CASET/RASET arguments are truncated to these low bits.
- `DEF_XE`, default 239: reset value of the column end.
- `DEF_YE`, default 134: reset value of the row end.
- `clk` in 1: system clock; must be at least 4x the SCK frequency.
- `resetn` in 1: synchronous, active-low reset.
- `spi_sck` in 1: serial clock from the driver; data is sampled on its rising edge.
- `spi_cs_n` in 1: chip select, active low.
- `spi_dc` in 1: 0 = command byte, 1 = data byte; sampled with the last bit of each byte.
- `spi_mosi` in 1: serial data, MSB first.
- `cmd_valid` out 1: one-cycle pulse per received command byte.
- `cmd_byte` out 8: opcode; held until the next command.
- `pix_valid` out 1: one-cycle pulse per complete RGB565 pixel.
- `pix_data` out 16: pixel value, first byte in [15:8].
- `pix_x` out COORD_W: column of the current pixel.
- `pix_y` out COORD_W: row of the current pixel.
- `frame_done` out 1: one-cycle pulse, coincident with `pix_valid` of the last pixel of the window.
- `sleep_out` out 1: level; 1 after SLPOUT (0x11), 0 after SLPIN (0x10).
- `display_on` out 1: level; 1 after DISPON (0x29), 0 after DISPOFF (0x28).
- `err` out 1: one-cycle pulse on a partial byte at CS rise, or on an invalid window at RAMWR.

## Operation
- **Front end:**
  - Two-flop synchronizers on all four SPI inputs.
  - A rising edge of the synchronized SCK while synchronized CS is low shifts MOSI into an 8-bit register, MSB first, and increments a 3-bit counter.
  - On the 8th bit the front end presents the byte together with DC as sampled on that same edge.
- **CS rise:** the bit counter clears. If the counter was nonzero, the partial byte is discarded and `err` pulses. Decoder state is not changed by CS; CS may toggle between every byte, as the driver does.
- **Command byte (DC=0):** `cmd_valid` pulses, `cmd_byte` updates, the argument index clears, and the pixel phase clears. Next state by opcode:
  - 0x2A → CASET.
  - 0x2B → RASET.
  - 0x2C → RAMWR.
  - 0x11/0x10 update `sleep_out`, then → IGNORE.
  - 0x29/0x28 update `display_on`, then → IGNORE.
  - Any other opcode → IGNORE.
- **Decoder FSM:** states IDLE (reset), CASET, RASET, RAMWR, IGNORE.
  - CASET data bytes, by argument index 0..3: xs[15:8], xs[7:0], xe[15:8], xe[7:0], each truncated to COORD_W. After index 3 → IGNORE.
  - RASET: the same layout into ys/ye.
  - IGNORE and IDLE: data bytes are dropped.
- **RAMWR entry:**
  - x is set to xs and y to ys.
  - If xs>xe or ys>ye, `err` pulses and the state goes to IGNORE.
- **RAMWR data bytes:**
  - Phase 0 latches the high byte.
  - Phase 1 pulses `pix_valid` with {hi,lo} at the current (x,y).
  - Advance rule: if x==xe, x←xs; then if y==ye, y←ys and `frame_done` pulses, else y←y+1. Otherwise x←x+1.
  - Pixels past the window end wrap to (xs,ys) and continue.
- **Command inside RAMWR:** terminates the stream; a pending odd high byte is dropped silently.
- **Reset values:** all pulse outputs 0, `cmd_byte`=0x00, `pix_data`=0, `pix_x`/`pix_y`=0, `sleep_out`=0, `display_on`=0, xs=ys=0, xe=DEF_XE, ye=DEF_YE. Reset mid-byte or mid-frame discards everything in flight.

## Timing
- Let N be the clk edge at which the first synchronizer flop captures SCK high for bit 8. `cmd_valid`/`pix_valid`/`frame_done` are asserted, registered, during cycle N+3, for exactly one cycle.
- `pix_data`, `pix_x` and `pix_y` are valid in the same cycle as `pix_valid`. They hold until the next pixel.
- `sleep_out`/`display_on` change in the same cycle as the corresponding `cmd_valid`.
- `err` for a CS rise is asserted 3 cycles after the first flop captures CS high.
- Minimum SCK high and SCK low time: 2 clk cycles each. Faster input is not supported and need not be detected.
- No back-pressure: the consumer must accept one pixel per 16 SCK periods.

## Structure
- Package `spi_lcd_pkg`:
  - Opcode constants: SLPIN, SLPOUT, DISPOFF, DISPON, CASET, RASET, RAMWR.
  - Decoder state enum.
  - RGB565 pixel typedef.
- Sub-module `spi_byte_rx`: synchronizers, SCK edge detect, shift register, bit counter. Outputs byte_valid, byte, dc, and the partial-byte error.
- The top level holds the decoder FSM, the window registers and the coordinate counters.

## Test plan
- **Wakeup:** reset 10 cycles, then send command 0x11 → `cmd_valid` with 0x11, `sleep_out` 0→1 in that cycle, no `err`.
- **Full frame:**
  - Stimulus: CASET 00 28 01 17, RASET 00 35 00 BB, RAMWR, then 240x135 pixels with value = index.
  - Required: 32400 `pix_valid` pulses; first at (40,53); x wraps 279→40; last at (279,187) with `frame_done` set.
- **Wrap:** window 2x2 (xs=xe-1, ys=ye-1), send 5 pixels → coordinates (xs,ys), (xe,ys), (xs,ye), (xe,ye) with `frame_done`, then (xs,ys).
- **Truncation:** CS raised after 5 bits of a data byte → `err` pulse, no `pix_valid`; the next full pixel is still decoded correctly at the expected coordinate.
- **Interruption:** RAMWR, 3 data bytes, then command 0x29 → one `pix_valid`, odd byte dropped, `display_on`=1, state IGNORE.
- **Invalid window, then reset:**
  - CASET with xs=10, xe=5, then RAMWR → `err` pulses, and subsequent data produces no `pix_valid`.
  - Assert `resetn` low mid-byte → all outputs return to their reset values on the next clk.
